// File: rtl/led_pkg.sv
// Shared constants for the board LED pattern generator.
package led_pkg;

   // Pattern modes, sampled on every tick
   localparam logic [1:0] MODE_ROL   = 2'd0;
   localparam logic [1:0] MODE_ROR   = 2'd1;
   localparam logic [1:0] MODE_PING  = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

   // Ping-pong travel direction: up moves the lit bit towards the MSB
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // One second at 50 MHz, expressed as interval minus one
   localparam logic [31:0] DEF_PERIOD_50M = 32'd49_999_999;

endpackage

// File: rtl/led_tick_timer.sv
// Programmable interval timer for the LED pattern generator.
// Counts 0..period_r while enabled and raises tick on the cycle where the
// count has reached the period, so the consumer updates on that edge.
module led_tick_timer
   import led_pkg::*;
#(
   parameter int unsigned         PERIOD_W   = 32,
   parameter logic [PERIOD_W-1:0] DEF_PERIOD = PERIOD_W'(DEF_PERIOD_50M)
) (
   input  logic                fpga_clk_50,
   input  logic                rst,
   input  logic                en,
   input  logic                clr,
   input  logic                period_we,
   input  logic [PERIOD_W-1:0] period_i,
   output logic                tick
);

   localparam logic [PERIOD_W-1:0] TIMER_ZERO = {PERIOD_W{1'b0}};
   localparam logic [PERIOD_W-1:0] TIMER_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

   logic [PERIOD_W-1:0] timer_r;
   logic [PERIOD_W-1:0] period_r;
   logic [PERIOD_W-1:0] timer_nxt_s;
   logic [PERIOD_W-1:0] period_nxt_s;
   logic                tick_s;

   // Next timer/period values; clear beats tick beats shrink-clear beats count
   always_comb begin
      tick_s       = 1'b0;
      timer_nxt_s  = timer_r;
      period_nxt_s = period_r;

      // >= rather than == so a count left just above a freshly shrunk period
      // still returns to zero instead of running round the full counter range
      if (en && (timer_r >= period_r)) begin
         tick_s = 1'b1;
      end else begin
         tick_s = 1'b0;
      end

      if (period_we) begin
         period_nxt_s = period_i;
      end else begin
         period_nxt_s = period_r;
      end

      if (clr) begin
         timer_nxt_s = TIMER_ZERO;
      end else if (tick_s) begin
         timer_nxt_s = TIMER_ZERO;
      end else if (period_we && (timer_r > period_i)) begin
         timer_nxt_s = TIMER_ZERO;
      end else if (en) begin
         timer_nxt_s = timer_r + TIMER_ONE;
      end else begin
         timer_nxt_s = timer_r;
      end
   end

   // Timer and period registers
   always_ff @(posedge fpga_clk_50 or posedge rst) begin
      if (rst) begin
         timer_r  <= TIMER_ZERO;
         period_r <= DEF_PERIOD;
      end else begin
         timer_r  <= timer_nxt_s;
         period_r <= period_nxt_s;
      end
   end

   assign tick = tick_s;

endmodule

// File: rtl/led_pattern_gen.sv
// Timed LED pattern generator: rotate-left, rotate-right, ping-pong or blink
// on N_LED outputs, with programmable tick period and pattern preload.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int unsigned         N_LED      = 4,
   parameter int unsigned         PERIOD_W   = 32,
   parameter logic [N_LED-1:0]    INIT       = {{(N_LED-1){1'b0}}, 1'b1},
   parameter logic [PERIOD_W-1:0] DEF_PERIOD = PERIOD_W'(DEF_PERIOD_50M)
) (
   input  logic                fpga_clk_50,
   input  logic                fpga_rst,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic                period_we,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic                load,
   input  logic [N_LED-1:0]    load_val,
   output logic [N_LED-1:0]    led_o,
   output logic                tick_o,
   output logic                wrap_o
);

   logic [1:0]       rst_sync_r;
   logic             rst_s;
   logic             tick_s;

   logic [N_LED-1:0] led_r;
   logic [N_LED-1:0] base_r;
   logic             dir_r;
   logic             tick_r;
   logic             wrap_r;

   logic [N_LED-1:0] led_nxt_s;
   logic [N_LED-1:0] base_nxt_s;
   logic             dir_nxt_s;
   logic             tick_nxt_s;
   logic             wrap_nxt_s;

   // Reset asserts immediately but releases only on a clock edge
   always_ff @(posedge fpga_clk_50 or posedge fpga_rst) begin
      if (fpga_rst) begin
         rst_sync_r <= 2'b11;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b0};
      end
   end

   assign rst_s = rst_sync_r[1];

   led_tick_timer #(
      .PERIOD_W   (PERIOD_W),
      .DEF_PERIOD (DEF_PERIOD)
   ) u_timer (
      .fpga_clk_50 (fpga_clk_50),
      .rst         (rst_s),
      .en          (en),
      .clr         (load),
      .period_we   (period_we),
      .period_i    (period_i),
      .tick        (tick_s)
   );

   // Next pattern, direction and pulses; a load overrides a coincident tick
   always_comb begin
      led_nxt_s  = led_r;
      base_nxt_s = base_r;
      dir_nxt_s  = dir_r;
      tick_nxt_s = 1'b0;
      wrap_nxt_s = 1'b0;

      if (load) begin
         led_nxt_s  = load_val;
         base_nxt_s = load_val;
         dir_nxt_s  = DIR_UP;
      end else if (tick_s) begin
         tick_nxt_s = 1'b1;
         case (mode)
            MODE_ROL: begin
               led_nxt_s  = {led_r[N_LED-2:0], led_r[N_LED-1]};
               wrap_nxt_s = led_r[N_LED-1];
            end
            MODE_ROR: begin
               led_nxt_s  = {led_r[0], led_r[N_LED-1:1]};
               wrap_nxt_s = led_r[0];
            end
            MODE_PING: begin
               // Reversal happens when the leading edge reaches the end bit
               if (dir_r == DIR_UP) begin
                  if (led_r[N_LED-1]) begin
                     dir_nxt_s  = DIR_DOWN;
                     led_nxt_s  = led_r >> 1'b1;
                     wrap_nxt_s = 1'b1;
                  end else begin
                     led_nxt_s  = led_r << 1'b1;
                  end
               end else begin
                  if (led_r[0]) begin
                     dir_nxt_s  = DIR_UP;
                     led_nxt_s  = led_r << 1'b1;
                     wrap_nxt_s = 1'b1;
                  end else begin
                     led_nxt_s  = led_r >> 1'b1;
                  end
               end
            end
            MODE_BLINK: begin
               led_nxt_s  = ~led_r;
               wrap_nxt_s = ((~led_r) == base_r);
            end
            default: begin
               led_nxt_s  = led_r;
               wrap_nxt_s = 1'b0;
            end
         endcase
      end else begin
         tick_nxt_s = 1'b0;
         wrap_nxt_s = 1'b0;
      end
   end

   // Pattern state and registered status pulses
   always_ff @(posedge fpga_clk_50 or posedge rst_s) begin
      if (rst_s) begin
         led_r  <= INIT;
         base_r <= INIT;
         dir_r  <= DIR_UP;
         tick_r <= 1'b0;
         wrap_r <= 1'b0;
      end else begin
         led_r  <= led_nxt_s;
         base_r <= base_nxt_s;
         dir_r  <= dir_nxt_s;
         tick_r <= tick_nxt_s;
         wrap_r <= wrap_nxt_s;
      end
   end

   assign led_o  = led_r;
   assign tick_o = tick_r;
   assign wrap_o = wrap_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed scenarios plus a random
// run, all compared against a cycle reference model built from the rules.
module tb_led_pattern_gen;

   localparam int N    = 4;
   localparam int MASK = (1 << N) - 1;

   logic        fpga_clk_50 = 1'b0;
   logic        fpga_rst;
   logic        en;
   logic [1:0]  mode;
   logic        period_we;
   logic [31:0] period_i;
   logic        load;
   logic [3:0]  load_val;
   logic [3:0]  led_o;
   logic        tick_o;
   logic        wrap_o;

   int checks = 0;
   int errors = 0;

   // reference model state
   int unsigned m_timer;
   int unsigned m_period;
   int          m_led;
   int          m_base;
   bit          m_down;
   bit          m_tick;
   bit          m_wrap;

   led_pattern_gen dut (
      .fpga_clk_50 (fpga_clk_50),
      .fpga_rst    (fpga_rst),
      .en          (en),
      .mode        (mode),
      .period_we   (period_we),
      .period_i    (period_i),
      .load        (load),
      .load_val    (load_val),
      .led_o       (led_o),
      .tick_o      (tick_o),
      .wrap_o      (wrap_o)
   );

   always #10 fpga_clk_50 = ~fpga_clk_50;

   task automatic model_reset();
      m_timer  = 0;
      m_period = 49_999_999;
      m_led    = 1;
      m_base   = 1;
      m_down   = 1'b0;
      m_tick   = 1'b0;
      m_wrap   = 1'b0;
   endtask

   // Drive one clock of inputs, advance the model, sample 1 ns after the edge
   task automatic cyc(input bit e, input bit [1:0] md, input bit we,
                      input int unsigned pi, input bit ld, input bit [3:0] lv);
      bit due;
      int top;
      en = e; mode = md; period_we = we; period_i = pi; load = ld; load_val = lv;
      due    = e && (m_timer == m_period);
      top    = (m_led >> (N - 1)) & 1;
      m_tick = 1'b0;
      m_wrap = 1'b0;
      if (ld) begin
         m_led  = lv;
         m_base = lv;
         m_down = 1'b0;
      end else if (due) begin
         m_tick = 1'b1;
         case (md)
            2'd0: begin m_wrap = (top == 1); m_led = ((m_led * 2) + top) & MASK; end
            2'd1: begin m_wrap = (m_led % 2 == 1); m_led = (m_led / 2) + ((m_led % 2) << (N - 1)); end
            2'd2: begin
               if (!m_down && top == 1) begin m_down = 1'b1; m_wrap = 1'b1; m_led = m_led / 2; end
               else if (!m_down) m_led = (m_led * 2) & MASK;
               else if (m_led % 2 == 1) begin m_down = 1'b0; m_wrap = 1'b1; m_led = (m_led * 2) & MASK; end
               else m_led = m_led / 2;
            end
            default: begin m_led = MASK - m_led; m_wrap = (m_led == m_base); end
         endcase
      end
      if (ld) m_timer = 0;
      else if (due) m_timer = 0;
      else if (we && m_timer > pi) m_timer = 0;
      else if (e) m_timer = m_timer + 1;
      if (we) m_period = pi;
      @(posedge fpga_clk_50);
      #1;
      load = 1'b0;
      period_we = 1'b0;
   endtask

   task automatic test_reset();
      fpga_rst = 1'b1; en = 1'b0; mode = 2'd0; period_we = 1'b0;
      period_i = 32'd0; load = 1'b0; load_val = 4'd0;
      repeat (3) @(posedge fpga_clk_50);
      #1;
      checks++;
      if (led_o !== 4'b0001 || tick_o !== 1'b0 || wrap_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: led=%b tick=%b wrap=%b, expected 0001 0 0", led_o, tick_o, wrap_o);
      end
      fpga_rst = 1'b0;
      model_reset();
      repeat (3) cyc(1'b0, 2'd0, 1'b0, 0, 1'b0, 4'd0);
      checks++;
      if (dut.u_timer.period_r !== 32'd49_999_999) begin
         errors++;
         $display("FAIL default_period: got %0d, expected 49999999", dut.u_timer.period_r);
      end
      for (int i = 0; i < 200; i++) begin
         cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
         checks++;
         if (led_o !== 4'b0001 || tick_o !== 1'b0 || wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL default_run: led=%b tick=%b wrap=%b, expected 0001 0 0", led_o, tick_o, wrap_o);
         end
      end
   endtask

   task automatic test_rotate_left();
      logic [3:0] exp_led [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic       exp_wrap [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      cyc(1'b1, 2'd0, 1'b1, 3, 1'b1, 4'b0001);
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) begin
            cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
            checks++;
            if (led_o !== m_led[3:0] || tick_o !== m_tick || wrap_o !== m_wrap) begin
               errors++;
               $display("FAIL rol_model: led=%b tick=%b wrap=%b, expected %b %b %b", led_o, tick_o, wrap_o, m_led[3:0], m_tick, m_wrap);
            end
            checks++;
            if (tick_o !== (j == 3) || (j == 3 && (led_o !== exp_led[k] || wrap_o !== exp_wrap[k]))) begin
               errors++;
               $display("FAIL rol_step%0d_%0d: led=%b tick=%b wrap=%b, expected led %b wrap %b on 4th clock", k, j, led_o, tick_o, wrap_o, exp_led[k], exp_wrap[k]);
            end
         end
      end
   endtask

   task automatic test_ping_pong();
      logic [3:0] exp_led [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      logic       exp_wrap [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      cyc(1'b1, 2'd2, 1'b0, 0, 1'b1, 4'b0001);
      for (int k = 0; k < 7; k++) begin
         repeat (4) cyc(1'b1, 2'd2, 1'b0, 0, 1'b0, 4'd0);
         checks++;
         if (led_o !== exp_led[k] || tick_o !== 1'b1 || wrap_o !== exp_wrap[k]) begin
            errors++;
            $display("FAIL ping_step%0d: led=%b tick=%b wrap=%b, expected %b 1 %b", k, led_o, tick_o, wrap_o, exp_led[k], exp_wrap[k]);
         end
      end
   endtask

   task automatic test_blink_en();
      logic [3:0] exp_led [2] = '{4'b0101, 4'b1010};
      logic       exp_wrap [2] = '{1'b0, 1'b1};
      cyc(1'b1, 2'd3, 1'b0, 0, 1'b1, 4'b1010);
      for (int k = 0; k < 2; k++) begin
         repeat (4) cyc(1'b1, 2'd3, 1'b0, 0, 1'b0, 4'd0);
         checks++;
         if (led_o !== exp_led[k] || tick_o !== 1'b1 || wrap_o !== exp_wrap[k]) begin
            errors++;
            $display("FAIL blink_step%0d: led=%b tick=%b wrap=%b, expected %b 1 %b", k, led_o, tick_o, wrap_o, exp_led[k], exp_wrap[k]);
         end
      end
      repeat (2) cyc(1'b1, 2'd3, 1'b0, 0, 1'b0, 4'd0);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 2'd3, 1'b0, 0, 1'b0, 4'd0);
         checks++;
         if (led_o !== 4'b1010 || tick_o !== 1'b0 || wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL en_freeze%0d: led=%b tick=%b wrap=%b, expected 1010 0 0", i, led_o, tick_o, wrap_o);
         end
      end
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 2'd3, 1'b0, 0, 1'b0, 4'd0);
         checks++;
         if (tick_o !== (i == 1) || led_o !== ((i == 1) ? 4'b0101 : 4'b1010) || wrap_o !== 1'b0) begin
            errors++;
            $display("FAIL en_resume%0d: led=%b tick=%b wrap=%b, expected tick only on 2nd clock", i, led_o, tick_o, wrap_o);
         end
      end
   endtask

   task automatic test_period_shrink();
      cyc(1'b1, 2'd0, 1'b1, 100, 1'b1, 4'b0001);
      repeat (50) cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
      cyc(1'b1, 2'd0, 1'b1, 10, 1'b0, 4'd0);
      checks++;
      if (tick_o !== 1'b0 || led_o !== 4'b0001) begin
         errors++;
         $display("FAIL shrink_clear: led=%b tick=%b, expected 0001 0", led_o, tick_o);
      end
      for (int j = 1; j <= 11; j++) begin
         cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
         checks++;
         if (tick_o !== (j == 11)) begin
            errors++;
            $display("FAIL shrink_tick%0d: tick=%b, expected %b", j, tick_o, (j == 11));
         end
      end
      repeat (3) cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
      cyc(1'b1, 2'd0, 1'b1, 0, 1'b0, 4'd0);
      for (int j = 0; j < 8; j++) begin
         cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
         checks++;
         if (tick_o !== 1'b1 || led_o !== m_led[3:0]) begin
            errors++;
            $display("FAIL period0_tick%0d: led=%b tick=%b, expected %b 1", j, led_o, tick_o, m_led[3:0]);
         end
      end
   endtask

   task automatic test_collision();
      cyc(1'b1, 2'd0, 1'b1, 3, 1'b1, 4'b0001);
      repeat (3) cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
      cyc(1'b1, 2'd0, 1'b0, 0, 1'b1, 4'b0100);
      checks++;
      if (led_o !== 4'b0100 || tick_o !== 1'b0 || wrap_o !== 1'b0) begin
         errors++;
         $display("FAIL load_vs_tick: led=%b tick=%b wrap=%b, expected 0100 0 0", led_o, tick_o, wrap_o);
      end
      for (int j = 1; j <= 4; j++) begin
         cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
         checks++;
         if (tick_o !== (j == 4) || led_o !== ((j == 4) ? 4'b1000 : 4'b0100)) begin
            errors++;
            $display("FAIL after_load%0d: led=%b tick=%b, expected tick+1000 on 4th clock", j, led_o, tick_o);
         end
      end
      repeat (2) cyc(1'b1, 2'd0, 1'b0, 0, 1'b0, 4'd0);
      fpga_rst = 1'b1;
      #1;
      checks++;
      if (led_o !== 4'b0001 || tick_o !== 1'b0 || wrap_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: led=%b tick=%b wrap=%b, expected 0001 0 0", led_o, tick_o, wrap_o);
      end
      @(posedge fpga_clk_50);
      #1;
      fpga_rst = 1'b0;
      model_reset();
      repeat (3) cyc(1'b0, 2'd0, 1'b0, 0, 1'b0, 4'd0);
   endtask

   task automatic test_random();
      bit          e, we, ld;
      bit [1:0]    md;
      int unsigned pi;
      bit [3:0]    lv;
      cyc(1'b1, 2'd0, 1'b1, 3, 1'b1, 4'b0001);
      for (int i = 0; i < 3000; i++) begin
         e  = ($urandom_range(0, 9) != 0);
         md = 2'($urandom_range(0, 3));
         we = ($urandom_range(0, 29) == 0);
         pi = $urandom_range(0, 6);
         if (pi == m_timer) we = 1'b0;
         ld = ($urandom_range(0, 39) == 0);
         lv = 4'($urandom);
         cyc(e, md, we, pi, ld, lv);
         checks++;
         if (led_o !== m_led[3:0] || tick_o !== m_tick || wrap_o !== m_wrap) begin
            errors++;
            $display("FAIL random%0d: led=%b tick=%b wrap=%b, expected %b %b %b", i, led_o, tick_o, wrap_o, m_led[3:0], m_tick, m_wrap);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotate_left();
      test_ping_pong();
      test_blink_en();
      test_period_shrink();
      test_collision();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
